encrypt_pipe_classify_stage: RTL and testbench
==============================================

// Module: encrypt_pipe_classify_stage
// PURPOSE
//  Parametrised first stage of the shift-cipher pipeline, processing LANES characters per beat.
//  - Each lane is classified as upper-case or lower-case alpha.
//  - Each alpha lane gets a one-hot ALPHA-bit position vector for the rotate stage.
//  - Accepted alpha beats are counted; the beat that completes rot_freq of them is tagged
//    with out_rot_tick to trigger key rotation.
//  - Valid/ready handshake on both sides; a 2-entry skid buffer gives full throughput
//    under backpressure.
// PARAMETERS
//  LANES   1   characters per beat (>=1)
//  ALPHA   26  alphabet size; one-hot width per lane (1..26)
//  CNT_W   3   width of rot_freq and of the internal alpha-beat counter
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          reset, asynchronous, active-low
//  in_valid      in   1          input beat valid
//  in_ready      out  1          stage can accept a beat
//  in_data       in   8*LANES    characters; lane i = [8i+7:8i]
//  mode          in   1          1 = encrypt path active; sampled with beat
//  shift_en      in   1          1 = shift cipher enabled; sampled with beat
//  rot_freq      in   CNT_W      alpha beats per rotation tick; 0 = never tick
//  out_valid     out  1          output beat valid
//  out_ready     in   1          downstream accepts beat
//  out_data      out  8*LANES    in_data passed through unchanged
//  out_upper     out  LANES      lane is upper-case alpha
//  out_lower     out  LANES      lane is lower-case alpha
//  out_onehot    out  ALPHA*LANES lane i = [ALPHA*i+ALPHA-1:ALPHA*i]
//  out_mode      out  1          mode of this beat
//  out_shift_en  out  1          shift_en of this beat
//  out_rot_tick  out  1          this beat completes a rotation period
// BEHAVIOUR
//  Reset (rst low): all outputs 0, including in_ready; counter=0, skid empty.
//   in_ready rises on first clk edge after rst release.
//   Mid-operation reset discards all buffered beats immediately.
//  Handshake:
//   - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
//   - out_valid and all out_* are registered and stable while out_valid&!out_ready.
//   - Latency: a beat accepted in cycle N is at the output in cycle N+1 if the output
//     register is empty or draining.
//   - If the output register is held, the beat goes to the skid register.
//   - in_ready is registered, = !skid_valid; drops the cycle after the skid fills.
//   - Order is always preserved; no beat is dropped or duplicated.
//   - Sustained 1 beat/cycle when out_ready is held high.
//  Classification, per lane, when mode&shift_en=1:
//   - upper = (d>=65 && d<=64+ALPHA); lower = (d>=97 && d<=96+ALPHA). Bounds inclusive.
//   - onehot = 1<<(d-65) if upper, 1<<(d-97) if lower, else all 0.
//   - If mode&shift_en=0: upper=lower=0 and onehot=0 for every lane.
//   - out_data is passed through unchanged in all cases.
//  Rotation counter (advances only on input transfer):
//   - Qualifying beat: mode&shift_en=1 and at least one lane upper|lower.
//   - On a qualifying beat with rot_freq!=0 and cnt+1>=rot_freq: the beat's tick=1 and
//     cnt<=0. Otherwise, on a qualifying beat, cnt<=cnt+1 (saturating at all-ones).
//   - rot_freq==0: tick never set, cnt held.
//   - Lowering rot_freq below cnt mid-period ticks on the next qualifying beat.
//   - The tick is captured with the beat and travels through the skid with it.
// TESTING
//  1. LANES=1, mode=shift_en=1, send 'A'(65) 'Z'(90) 'a'(97) 'z'(122) '@'(64) '['(91)
//     -> upper 1,1,0,0,0,0; lower 0,0,1,1,0,0; onehot bit0,bit25,bit0,bit25,0,0;
//     data unchanged.
//  2. rot_freq=3, 7 alpha beats interleaved with '5'(53) beats
//     -> tick on alpha beats 3 and 6 only; non-alpha beats never tick and never count.
//  3. Stream 8 beats with out_ready low for cycles 2-5
//     -> in_ready low from cycle 3 until out_ready returns.
//     -> out_data order 0..7, no loss or duplication; outputs stable while stalled.
//  4. mode=0 or shift_en=0 with 'M'(77)
//     -> upper=lower=0, onehot=0, data=77, counter unchanged.
//  5. LANES=4, ALPHA=26, data "aB3z"
//     -> upper=4'b0010, lower=4'b1001, onehot lanes: bit0, bit1, 0, bit25.
//  6. rst low with 2 beats buffered and cnt=2
//     -> out_valid=0, in_ready=0 at once; after release the first alpha beat with
//        rot_freq=3 does not tick.

Source files
------------

// File: rtl/encrypt_pipe_classify_stage.sv
`default_nettype none
// ============================================================================
// Module  : encrypt_pipe_classify_stage
// Brief   : Shift-cipher front stage: per-lane alpha classification, one-hot
//           position, rotation tick, valid/ready with a 2-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module encrypt_pipe_classify_stage #(
    parameter int LANES = 1,
    parameter int ALPHA = 26,
    parameter int CNT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*LANES-1:0]       in_data,
    input  logic                     mode,
    input  logic                     shift_en,
    input  logic [CNT_W-1:0]         rot_freq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*LANES-1:0]       out_data,
    output logic [LANES-1:0]         out_upper,
    output logic [LANES-1:0]         out_lower,
    output logic [ALPHA*LANES-1:0]   out_onehot,
    output logic                     out_mode,
    output logic                     out_shift_en,
    output logic                     out_rot_tick
);

    localparam int c_UP_O = 8*LANES;
    localparam int c_LO_O = c_UP_O + LANES;
    localparam int c_OH_O = c_LO_O + LANES;
    localparam int c_MD_O = c_OH_O + ALPHA*LANES;
    localparam int c_PW   = c_MD_O + 3;

    localparam logic [7:0]       c_UPPER_LO = 8'd65;
    localparam logic [7:0]       c_UPPER_HI = 8'(64 + ALPHA);
    localparam logic [7:0]       c_LOWER_LO = 8'd97;
    localparam logic [7:0]       c_LOWER_HI = 8'(96 + ALPHA);
    localparam logic [ALPHA-1:0] c_ONE      = ALPHA'(1);

    logic                   w_active;
    logic [LANES-1:0]       w_upper;
    logic [LANES-1:0]       w_lower;
    logic [ALPHA*LANES-1:0] w_onehot;
    logic                   w_qual;
    logic                   w_tick;
    logic [CNT_W:0]         w_cnt_inc;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_in_xfer;
    logic                   w_out_free;
    logic                   w_skid_next;
    logic [c_PW-1:0]        w_in_pay;

    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [c_PW-1:0]        r_out_pay;
    logic                   r_skid_valid;
    logic [c_PW-1:0]        r_skid_pay;
    logic [CNT_W-1:0]       r_cnt;

    assign w_active = mode & shift_en;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] w_d;
            assign w_d         = in_data[8*gi +: 8];
            assign w_upper[gi] = w_active && (w_d >= c_UPPER_LO) && (w_d <= c_UPPER_HI);
            assign w_lower[gi] = w_active && (w_d >= c_LOWER_LO) && (w_d <= c_LOWER_HI);
            assign w_onehot[ALPHA*gi +: ALPHA] =
                w_upper[gi] ? (c_ONE << (w_d - c_UPPER_LO)) :
                w_lower[gi] ? (c_ONE << (w_d - c_LOWER_LO)) : '0;
        end
    endgenerate

    // Tick fires on the beat that brings the count up to rot_freq; a lowered
    // rot_freq (already below the count) therefore ticks on the next alpha beat.
    assign w_qual    = w_active && |(w_upper | w_lower);
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_tick    = w_qual && (rot_freq != '0) && (w_cnt_inc >= {1'b0, rot_freq});

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_qual && (rot_freq != '0)) begin
            if (w_tick)
                w_cnt_next = '0;
            else if (!(&r_cnt))
                w_cnt_next = w_cnt_inc[CNT_W-1:0];
        end
    end

    assign w_in_pay    = {w_tick, shift_en, mode, w_onehot, w_lower, w_upper, in_data};
    assign w_in_xfer   = in_valid & r_in_ready;
    assign w_out_free  = !r_out_valid | out_ready;
    // in_ready is low whenever the skid is full, so a skid-to-output move never
    // coincides with an input transfer.
    assign w_skid_next = w_out_free ? 1'b0 : (r_skid_valid | w_in_xfer);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_pay    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_in_xfer)
                r_cnt <= w_cnt_next;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_pay   <= r_skid_pay;
                end else begin
                    r_out_valid <= w_in_xfer;
                    if (w_in_xfer)
                        r_out_pay <= w_in_pay;
                end
            end
            if (w_in_xfer && !w_out_free)
                r_skid_pay <= w_in_pay;
            r_skid_valid <= w_skid_next;
            r_in_ready   <= !w_skid_next;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_pay[0 +: 8*LANES];
    assign out_upper    = r_out_pay[c_UP_O +: LANES];
    assign out_lower    = r_out_pay[c_LO_O +: LANES];
    assign out_onehot   = r_out_pay[c_OH_O +: ALPHA*LANES];
    assign out_mode     = r_out_pay[c_MD_O];
    assign out_shift_en = r_out_pay[c_MD_O + 1];
    assign out_rot_tick = r_out_pay[c_MD_O + 2];

endmodule
`default_nettype wire

// File: tb/tb_encrypt_pipe_classify_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_encrypt_pipe_classify_stage
// Brief   : Randomised and directed bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_encrypt_pipe_classify_stage;

    localparam int LANES = 4;
    localparam int ALPHA = 26;
    localparam int CNT_W = 3;
    localparam int PW    = 8*LANES + 2*LANES + ALPHA*LANES + 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [8*LANES-1:0]     in_data = '0;
    logic                   mode = 1'b0;
    logic                   shift_en = 1'b0;
    logic [CNT_W-1:0]       rot_freq = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [8*LANES-1:0]     out_data;
    logic [LANES-1:0]       out_upper;
    logic [LANES-1:0]       out_lower;
    logic [ALPHA*LANES-1:0] out_onehot;
    logic                   out_mode;
    logic                   out_shift_en;
    logic                   out_rot_tick;

    always #5 clk = ~clk;

    encrypt_pipe_classify_stage #(.LANES(LANES), .ALPHA(ALPHA), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .shift_en(shift_en), .rot_freq(rot_freq),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_upper(out_upper), .out_lower(out_lower), .out_onehot(out_onehot),
        .out_mode(out_mode), .out_shift_en(out_shift_en), .out_rot_tick(out_rot_tick)
    );

    typedef struct {
        logic [8*LANES-1:0]     data;
        logic [LANES-1:0]       up;
        logic [LANES-1:0]       lo;
        logic [ALPHA*LANES-1:0] oh;
        logic                   md;
        logic                   sh;
        logic                   tk;
    } beat_t;

    beat_t q[$];
    int    m_cnt      = 0;
    int    ticks_seen = 0;
    int    checks     = 0;
    int    errors     = 0;

    // Reference: classify each character and advance the alpha-beat counter.
    function automatic beat_t model_beat(logic [8*LANES-1:0] d, logic md, logic sh, int rf);
        beat_t b;
        b.data = d; b.up = '0; b.lo = '0; b.oh = '0; b.md = md; b.sh = sh; b.tk = 1'b0;
        if (md && sh) begin
            for (int l = 0; l < LANES; l++) begin
                int c;
                c = int'(d[8*l +: 8]);
                if (c >= 65 && c < 65 + ALPHA) begin
                    b.up[l] = 1'b1;
                    b.oh[ALPHA*l + c - 65] = 1'b1;
                end else if (c >= 97 && c < 97 + ALPHA) begin
                    b.lo[l] = 1'b1;
                    b.oh[ALPHA*l + c - 97] = 1'b1;
                end
            end
            if ((b.up | b.lo) != '0 && rf != 0) begin
                if (m_cnt + 1 >= rf) begin
                    b.tk  = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
                end
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] rand_char();
        logic [7:0] edges [8];
        edges = '{8'd64, 8'd91, 8'd96, 8'd123, 8'd65, 8'd90, 8'd97, 8'd122};
        case ($urandom_range(0, 4))
            0:       return 8'(65 + $urandom_range(0, ALPHA - 1));
            1:       return 8'(97 + $urandom_range(0, ALPHA - 1));
            2:       return edges[$urandom_range(0, 7)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [8*LANES-1:0] rand_word();
        logic [8*LANES-1:0] w;
        for (int l = 0; l < LANES; l++) w[8*l +: 8] = rand_char();
        return w;
    endfunction

    // One clock of stimulus; scoreboard compares against the queue head.
    task automatic drive_cycle(input logic v, input logic [8*LANES-1:0] d, input logic md,
                               input logic sh, input logic [CNT_W-1:0] rf, input logic ordy,
                               output logic acc);
        logic [PW-1:0] act, exp;
        @(negedge clk);
        in_valid = v; in_data = d; mode = md; shift_en = sh; rot_freq = rf; out_ready = ordy;
        #1;
        checks++;
        if (out_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, q.size() > 0);
        end
        checks++;
        if (in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (held=%0d)", in_ready, q.size() < 2, q.size());
        end
        if (out_valid === 1'b1 && q.size() > 0) begin
            act = {out_data, out_upper, out_lower, out_onehot, out_mode, out_shift_en, out_rot_tick};
            exp = {q[0].data, q[0].up, q[0].lo, q[0].oh, q[0].md, q[0].sh, q[0].tk};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL out_beat: got %h expected %h", act, exp);
            end
            if (out_ready) begin
                if (out_rot_tick === 1'b1) ticks_seen++;
                void'(q.pop_front());
            end
        end
        acc = v && (in_ready === 1'b1);
        if (acc) q.push_back(model_beat(d, md, sh, int'(rf)));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && q.size() > 0; i++)
            drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats left expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        logic [PW-1:0] act;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        act = {out_data, out_upper, out_lower, out_onehot, out_mode, out_shift_en, out_rot_tick};
        checks++;
        if ({out_valid, in_ready, act} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%h expected all zero", out_valid, in_ready, act);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 1", in_ready);
        end
        q.delete();
        m_cnt = 0;
    endtask

    task automatic test_classify();
        logic [7:0] chars [6];
        logic acc;
        chars = '{8'd65, 8'd90, 8'd97, 8'd122, 8'd64, 8'd91};
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b1, {rand_word() >> 8, chars[i]} , 1'b1, 1'b1, '0, 1'b1, acc);
        drive_cycle(1'b1, {8'd122, 8'd51, 8'd66, 8'd97}, 1'b1, 1'b1, '0, 1'b1, acc);
        drain();
    endtask

    task automatic test_rot_tick();
        logic acc;
        ticks_seen = 0;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, {rand_word() >> 8, 8'(97 + $urandom_range(0, 25))}, 1'b1, 1'b1,
                        3'd3, 1'b1, acc);
            drive_cycle(1'b1, {LANES{8'd53}}, 1'b1, 1'b1, 3'd3, 1'b1, acc);
        end
        drain();
        checks++;
        if (ticks_seen != 2) begin
            errors++;
            $display("FAIL rot_tick_count: got %0d expected 2", ticks_seen);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        int idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            drive_cycle(1'b1, {LANES{8'(idx)}}, 1'b1, 1'b1, 3'd3, !(c >= 2 && c <= 5), acc);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready c%0d: got %b expected 0", c, in_ready);
                end
            end
            if (acc) idx++;
        end
        checks++;
        if (idx != 8) begin
            errors++;
            $display("FAIL stream_accept: got %0d beats expected 8", idx);
        end
        drain();
    endtask

    task automatic test_inactive();
        logic acc;
        ticks_seen = 0;
        drive_cycle(1'b1, {LANES{8'd77}}, 1'b0, 1'b1, 3'd1, 1'b1, acc);
        drive_cycle(1'b1, {LANES{8'd77}}, 1'b1, 1'b0, 3'd1, 1'b1, acc);
        drive_cycle(1'b1, {LANES{8'd77}}, 1'b0, 1'b0, 3'd1, 1'b1, acc);
        drain();
        checks++;
        if (ticks_seen != 0) begin
            errors++;
            $display("FAIL inactive_tick: got %0d expected 0", ticks_seen);
        end
        // Count left at 1 by the rotation test, so rot_freq=2 must tick now.
        drive_cycle(1'b1, {LANES{8'd77}}, 1'b1, 1'b1, 3'd2, 1'b1, acc);
        drain();
        checks++;
        if (ticks_seen != 1) begin
            errors++;
            $display("FAIL count_held: got %0d ticks expected 1", ticks_seen);
        end
    endtask

    task automatic test_random();
        logic acc;
        logic [CNT_W-1:0] rf = 3'd4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rf = CNT_W'($urandom_range(0, 7));
            drive_cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0, rf, $urandom_range(0, 9) < 7, acc);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        logic acc;
        logic [PW-1:0] act;
        int t0;
        drive_cycle(1'b1, {LANES{8'd66}}, 1'b1, 1'b1, 3'd1, 1'b1, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 3'd1, 1'b1, acc);
        drive_cycle(1'b1, {LANES{8'd99}}, 1'b1, 1'b1, 3'd7, 1'b0, acc);
        drive_cycle(1'b1, {LANES{8'd88}}, 1'b1, 1'b1, 3'd7, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 3'd7, 1'b0, acc);
        checks++;
        if (q.size() != 2 || m_cnt != 2) begin
            errors++;
            $display("FAIL pre_reset_fill: got %0d beats cnt %0d expected 2/2", q.size(), m_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        act = {out_data, out_upper, out_lower, out_onehot, out_mode, out_shift_en, out_rot_tick};
        checks++;
        if ({out_valid, in_ready, act} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%h expected all zero", out_valid, in_ready, act);
        end
        q.delete();
        m_cnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 3'd3, 1'b1, acc);
        t0 = ticks_seen;
        drive_cycle(1'b1, {LANES{8'd97}}, 1'b1, 1'b1, 3'd3, 1'b1, acc);
        drain();
        checks++;
        if (ticks_seen != t0) begin
            errors++;
            $display("FAIL post_reset_tick: got %0d ticks expected 0", ticks_seen - t0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_classify();
        test_rot_tick();
        test_backpressure();
        test_inactive();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
